// File: rtl/alpha_blend_pipe.sv
// Layered alpha compositor: folds a stream of layer beats into one accumulated
// pixel and emits the composite one cycle after the last layer is accepted.
module alpha_blend_pipe #(
    parameter int CW  = 4,
    parameter int NCH = 3,
    localparam int PW = (NCH + 1) * CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_pixel,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pixel,
    output logic [7:0]    out_layers
);

    typedef enum logic [1:0] {
        M_ALPHA   = 2'd0,
        M_ADD     = 2'd1,
        M_REPLACE = 2'd2,
        M_KEEP    = 2'd3
    } blend_mode_e;

    localparam int AW = NCH * CW;

    logic [AW-1:0] acc_q, acc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_pixel_q, out_pixel_d;
    logic [7:0]    out_layers_q, out_layers_d;
    logic [AW-1:0] blended;
    logic          accept;
    blend_mode_e   mode_e;

    // Alpha term: the signed product is arithmetically shifted, so the
    // division floors toward minus infinity and the result stays within [p, n].
    function automatic logic [CW-1:0] blend_ch(
        input logic [CW-1:0] p,
        input logic [CW-1:0] n,
        input logic [CW-1:0] a,
        input blend_mode_e   m
    );
        logic signed [CW+1:0]   diff;
        logic signed [2*CW+2:0] prod;
        logic signed [2*CW+2:0] sum;
        logic [CW:0]            add;
        logic [CW-1:0]          res;
        diff = $signed({2'b00, n}) - $signed({2'b00, p});
        prod = diff * $signed({1'b0, a});
        sum  = $signed({{(CW + 3){1'b0}}, p}) + (prod >>> CW);
        add  = {1'b0, p} + {1'b0, n};
        res  = p;
        case (m)
            M_ALPHA:   res = (a == '1) ? n : sum[CW-1:0];
            M_ADD:     res = add[CW] ? '1 : add[CW-1:0];
            M_REPLACE: res = (a != '0) ? n : p;
            default:   res = p;
        endcase
        return res;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign mode_e   = blend_mode_e'(mode);

    always_comb begin
        blended = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            blended[k*CW +: CW] = blend_ch(acc_q[k*CW +: CW], in_pixel[k*CW +: CW],
                                           in_pixel[NCH*CW +: CW], mode_e);
        end
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_pixel_d  = out_pixel_q;
        out_layers_d = out_layers_q;

        if (accept) begin
            if (in_first) begin
                acc_d = in_pixel[AW-1:0];
                cnt_d = 8'd1;
            end else begin
                acc_d = blended;
                cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
            end
        end

        // A new result overrides consumption of the old one in the same cycle.
        if (accept && in_last) begin
            out_valid_d  = 1'b1;
            out_pixel_d  = {{CW{1'b1}}, acc_d};
            out_layers_d = cnt_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            out_layers_q <= '0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            out_layers_q <= out_layers_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign out_layers = out_layers_q;

endmodule

// File: tb/tb_alpha_blend_pipe.sv
// Directed bench for alpha_blend_pipe at CW=4, NCH=3: vector table plus
// hand-written backpressure, reset and counter-saturation sequences.
module tb_alpha_blend_pipe;

    localparam int CW  = 4;
    localparam int NCH = 3;
    localparam int PW  = (NCH + 1) * CW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          in_first;
    logic          in_last;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pixel;
    logic [7:0]    out_layers;

    int n_vec;
    int n_err;

    alpha_blend_pipe #(.CW(CW), .NCH(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_first   (in_first),
        .in_last    (in_last),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_layers (out_layers)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        first;
        logic        last;
        logic [1:0]  mode;
        logic [15:0] pix;
        logic [15:0] exp_pix;
        logic [7:0]  exp_layers;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic f, input logic l, input logic [1:0] m,
                           input logic [15:0] p, input logic [15:0] ep,
                           input logic [7:0] el);
        vec_t v;
        v.first = f; v.last = l; v.mode = m; v.pix = p;
        v.exp_pix = ep; v.exp_layers = el;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic l,
                         input logic [1:0] m, input logic [15:0] p);
        in_valid = v; in_first = f; in_last = l; mode = m; in_pixel = p;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);

        // background, last, mode, pixel, expected out_pixel, expected out_layers
        add_vec(1, 0, 0, 16'h0444, 16'h0000, 8'd0);
        add_vec(0, 1, 0, 16'h8CCC, 16'hF888, 8'd2);
        add_vec(1, 0, 0, 16'h0CCC, 16'h0000, 8'd0);
        add_vec(0, 1, 0, 16'h8444, 16'hF888, 8'd2);
        add_vec(1, 0, 0, 16'h0555, 16'h0000, 8'd0);
        add_vec(0, 1, 0, 16'h1444, 16'hF444, 8'd2);
        add_vec(1, 0, 0, 16'h0555, 16'h0000, 8'd0);
        add_vec(0, 1, 0, 16'hF0A3, 16'hF0A3, 8'd2);
        add_vec(1, 0, 0, 16'h0000, 16'h0000, 8'd0);
        add_vec(0, 0, 0, 16'h8FFF, 16'h0000, 8'd0);
        add_vec(0, 1, 0, 16'h8000, 16'hF333, 8'd3);
        add_vec(1, 0, 0, 16'h0A12, 16'h0000, 8'd0);
        add_vec(0, 1, 1, 16'h0934, 16'hFF46, 8'd2);
        add_vec(1, 0, 0, 16'h0AAA, 16'h0000, 8'd0);
        add_vec(0, 1, 1, 16'h0999, 16'hFFFF, 8'd2);
        add_vec(1, 0, 0, 16'h0123, 16'h0000, 8'd0);
        add_vec(0, 1, 2, 16'h0FFF, 16'hF123, 8'd2);
        add_vec(1, 0, 0, 16'h0123, 16'h0000, 8'd0);
        add_vec(0, 1, 2, 16'h1ABC, 16'hFABC, 8'd2);
        add_vec(1, 0, 0, 16'h0123, 16'h0000, 8'd0);
        add_vec(0, 0, 3, 16'hFFFF, 16'h0000, 8'd0);
        add_vec(0, 1, 3, 16'hFFFF, 16'hF123, 8'd3);
        add_vec(1, 0, 0, 16'h0111, 16'h0000, 8'd0);
        add_vec(0, 0, 1, 16'h0222, 16'h0000, 8'd0);
        add_vec(1, 0, 0, 16'h0555, 16'h0000, 8'd0);
        add_vec(0, 1, 3, 16'h0000, 16'hF555, 8'd2);
        add_vec(1, 1, 1, 16'h7ABC, 16'hFABC, 8'd1);
        add_vec(1, 1, 0, 16'h0321, 16'hF321, 8'd1);

        step();
        step();
        rst = 1'b0;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_pixel", {16'd0, out_pixel}, 32'd0);
        check("reset out_layers", {24'd0, out_layers}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].first, tbl[i].last, tbl[i].mode, tbl[i].pix);
            step();
            check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].last});
            if (tbl[i].last) begin
                check($sformatf("vec%0d out_pixel", i), {16'd0, out_pixel}, {16'd0, tbl[i].exp_pix});
                check($sformatf("vec%0d out_layers", i), {24'd0, out_layers}, {24'd0, tbl[i].exp_layers});
            end
        end

        // Backpressure: stalled result holds, then is replaced without a gap.
        drive(1'b1, 1'b1, 1'b0, 2'd0, 16'h0444);
        step();
        drive(1'b1, 1'b0, 1'b1, 2'd0, 16'h8CCC);
        step();
        check("bp first result", {16'd0, out_pixel}, 32'hF888);
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 2'd0, 16'h0ABC);
        #1;
        check("bp in_ready low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp hold valid", {31'd0, out_valid}, 32'd1);
            check("bp hold pixel", {16'd0, out_pixel}, 32'hF888);
            check("bp hold layers", {24'd0, out_layers}, 32'd2);
        end
        out_ready = 1'b1;
        #1;
        check("bp in_ready high", {31'd0, in_ready}, 32'd1);
        step();
        check("bp replace valid", {31'd0, out_valid}, 32'd1);
        check("bp replace pixel", {16'd0, out_pixel}, 32'hFABC);
        check("bp replace layers", {24'd0, out_layers}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        step();
        check("drain out_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-composite, then a lone non-first last beat blends onto 0.
        drive(1'b1, 1'b1, 1'b0, 2'd0, 16'h0999);
        step();
        drive(1'b1, 1'b0, 1'b1, 2'd0, 16'h8999);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst out_pixel", {16'd0, out_pixel}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 16'h8888);
        step();
        check("lone valid", {31'd0, out_valid}, 32'd1);
        check("lone pixel", {16'd0, out_pixel}, 32'hF444);
        check("lone layers", {24'd0, out_layers}, 32'd1);

        // Layer counter saturates at 255.
        drive(1'b1, 1'b1, 1'b0, 2'd0, 16'h0000);
        step();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, (i == 299), 2'd3, 16'hFFFF);
            step();
        end
        check("sat valid", {31'd0, out_valid}, 32'd1);
        check("sat pixel", {16'd0, out_pixel}, 32'hF000);
        check("sat layers", {24'd0, out_layers}, 32'd255);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alpha_blend_pipe.md
ALPHA_BLEND_PIPE -- requirements
Module: alpha_blend_pipe

Interface
REQ-001 Parameter CW, default 4: bits per colour channel and per alpha field.
REQ-002 Parameter NCH, default 3: colour channel count; channel k occupies pixel bits [k*CW +: CW], alpha occupies [NCH*CW +: CW].
REQ-003 Parameter PW, derived, (NCH+1)*CW: pixel width.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port in_valid, input, 1: input beat present.
REQ-008 Port in_ready, output, 1: block accepts the beat this cycle.
REQ-009 Port in_pixel, input, PW: layer pixel {alpha, ch[NCH-1..0]}.
REQ-010 Port in_first, input, 1: beat is the background layer of a new composite.
REQ-011 Port in_last, input, 1: beat is the final layer of the composite.
REQ-012 Port mode, input, 2: blend mode for this beat; sampled with the beat.
REQ-013 Port out_valid, output, 1: composite result present.
REQ-014 Port out_ready, input, 1: downstream accepts the result.
REQ-015 Port out_pixel, output, PW: composited pixel, alpha field all ones.
REQ-016 Port out_layers, output, 8: beats in this composite, saturating at 255.

Function
REQ-017 A beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
REQ-018 in_ready = !out_valid || out_ready, combinationally.
REQ-019 Accumulator acc (NCH channels of CW bits) and layer counter cnt update only on acceptance.
REQ-020 Accepted beat with in_first: acc = in channels (alpha and mode ignored); cnt = 1.
REQ-021 Accepted beat without in_first: acc = blend(acc, in) per channel; cnt = min(cnt+1, 255).
REQ-022 Mode 0 ALPHA: p + floor(a*(n-p) / 2^CW), signed, floor toward minus infinity; if a == 2^CW-1, the result is exactly n.
REQ-023 Mode 1 ADD: min(p + n, 2^CW-1), ignoring alpha.
REQ-024 Mode 2 REPLACE: n if a != 0, else p.
REQ-025 Mode 3 reserved: p unchanged; the beat still counts toward cnt.
REQ-026 Intermediates are wide enough that no overflow occurs before the shift or saturation; ALPHA results always lie between p and n inclusive.
REQ-027 Accepted beat with in_last: on the next clock, out_valid = 1, out_pixel = {all ones, blended channels}, and out_layers = the updated cnt.
REQ-028 Latency from in_last acceptance to out_valid is exactly 1 cycle.
REQ-029 Throughput is one beat per cycle when out_ready is held high.
REQ-030 out_valid, out_pixel and out_layers hold stable while out_valid && !out_ready.
REQ-031 A result consumed in the same cycle that a new last beat is accepted is replaced by the new result, and out_valid stays 1.
REQ-032 A consumed result with no new last beat accepted clears out_valid on the next clock.
REQ-033 in_first && in_last on one beat: the result equals the input channels, and out_layers = 1.
REQ-034 A non-first beat arriving with no preceding first beat blends onto the current acc (0 after reset).
REQ-035 A second in_first before in_last discards the partial composite and emits no output for it.

Reset
REQ-036 When rst is 1 at a clock edge: out_valid = 0, out_pixel = 0, out_layers = 0, acc = 0, cnt = 0.
REQ-037 Reset mid-composite discards the partial composite and any pending result.
REQ-038 in_ready is 1 in the cycle after reset.

Verification
REQ-039 CW=4, NCH=3, mode 0: background {_,4,4,4} then last {8,12,12,12} -> after 1 cycle, out_pixel {F,8,8,8}, out_layers 2.
REQ-040 Mode 0: prev 12, new 4, a=8 -> channel 8; prev 5, new 4, a=1 -> channel 4 (floor); a=15 -> new exactly.
REQ-041 Mode 1: prev 10, new 9 -> 15 (saturated); mode 2 with a=0 -> prev; mode 3 -> prev, out_layers still incremented.
REQ-042 Hold out_ready=0 with a result pending and in_valid=1 -> in_ready=0, output stable; raise out_ready with a new last beat -> new result on the next cycle, out_valid never drops.
REQ-043 Assert rst between a first beat and its last beat -> out_valid=0, acc=0; a following lone non-first last beat {8,8,8,8} -> channels 4 (blend onto 0).
REQ-044 Stream 300 non-first beats after one first beat -> out_layers=255.
